// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that merges four byte producers onto the
// single uart_tx6 write port; a grant holds until packet end, byte limit or owner stall.
module uart_tx_arbiter #(
    parameter int MAX_PACKET = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [3:0]  req_last,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        buffer_write,
    output logic [7:0]  uart_data_write,
    input  logic        tx_full,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        timeout_release
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [7:0] MAX_PACKET_C = 8'(MAX_PACKET);
    localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);

    // First set request at or after ptr, wrapping mod 4 (smallest offset wins).
    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] sel;
        sel = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (valid[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    logic [0:0] state_r;
    logic [1:0] owner_r;
    logic [1:0] ptr_r;
    logic [7:0] byte_cnt_r;
    logic [7:0] idle_cnt_r;
    logic [3:0] grant_r;
    logic       busy_r;
    logic       timeout_release_r;

    logic       owner_valid_s;
    logic       owner_last_s;
    logic [7:0] owner_lane_s;
    logic       accept_s;
    logic [7:0] byte_cnt_nxt_s;
    logic [7:0] idle_cnt_nxt_s;
    logic       release_byte_s;
    logic       timeout_s;
    logic [1:0] pick_s;

    // Owner lane decode, accept qualification and release detection.
    always_comb begin
        owner_valid_s  = req_valid[owner_r];
        owner_last_s   = req_last[owner_r];
        owner_lane_s   = req_data[{owner_r, 3'b000} +: 8];
        byte_cnt_nxt_s = byte_cnt_r + 8'd1;
        idle_cnt_nxt_s = idle_cnt_r + 8'd1;
        pick_s         = rr_pick(req_valid, ptr_r);
        // tx_full is checked here so a write never lands on a full FIFO.
        if ((state_r == ST_LOCKED) && !reset) begin
            accept_s  = owner_valid_s & ~tx_full;
            timeout_s = ~owner_valid_s & (idle_cnt_nxt_s == TIMEOUT_C);
        end else begin
            accept_s  = 1'b0;
            timeout_s = 1'b0;
        end
        release_byte_s = accept_s & (owner_last_s | (byte_cnt_nxt_s == MAX_PACKET_C));
    end

    // Write-port handshake driven in the accept cycle itself.
    always_comb begin
        if (accept_s) begin
            req_ready       = 4'b0001 << owner_r;
            buffer_write    = 1'b1;
            uart_data_write = owner_lane_s;
        end else begin
            req_ready       = 4'b0000;
            buffer_write    = 1'b0;
            uart_data_write = 8'h00;
        end
    end

    // Arbitration FSM, counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            owner_r           <= 2'd0;
            ptr_r             <= 2'd0;
            byte_cnt_r        <= 8'd0;
            idle_cnt_r        <= 8'd0;
            grant_r           <= 4'b0000;
            busy_r            <= 1'b0;
            timeout_release_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timeout_release_r <= 1'b0;
                    if (|req_valid) begin
                        state_r    <= ST_LOCKED;
                        owner_r    <= pick_s;
                        byte_cnt_r <= 8'd0;
                        idle_cnt_r <= 8'd0;
                        grant_r    <= 4'b0001 << pick_s;
                        busy_r     <= 1'b1;
                    end else begin
                        grant_r <= 4'b0000;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    timeout_release_r <= timeout_s;
                    if (release_byte_s || timeout_s) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= owner_r + 2'd1;
                        grant_r <= 4'b0000;
                        busy_r  <= 1'b0;
                    end else begin
                        if (accept_s) begin
                            byte_cnt_r <= byte_cnt_nxt_s;
                        end else begin
                            byte_cnt_r <= byte_cnt_r;
                        end
                        // Only a missing owner byte counts as idle; FIFO backpressure does not.
                        if (owner_valid_s) begin
                            idle_cnt_r <= 8'd0;
                        end else begin
                            idle_cnt_r <= idle_cnt_nxt_s;
                        end
                    end
                end
                default: begin
                    state_r           <= ST_IDLE;
                    grant_r           <= 4'b0000;
                    busy_r            <= 1'b0;
                    timeout_release_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant           = grant_r;
    assign busy            = busy_r;
    assign timeout_release = timeout_release_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (MAX_PACKET=4, TIMEOUT=8).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic        tx_full;
    logic [3:0]  req_ready;
    logic        buffer_write;
    logic [7:0]  uart_data_write;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_release;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.MAX_PACKET(4), .TIMEOUT(8)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .buffer_write(buffer_write),
        .uart_data_write(uart_data_write),
        .tx_full(tx_full),
        .grant(grant),
        .busy(busy),
        .timeout_release(timeout_release)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_bw;
        logic [7:0]  e_data;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_to;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [3:0] last,
                                input logic [31:0] data, input logic full, input logic [3:0] e_ready,
                                input logic e_bw, input logic [7:0] e_data, input logic [3:0] e_grant,
                                input logic e_busy, input logic e_to);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.data = data; v.full = full;
        v.e_ready = e_ready; v.e_bw = e_bw; v.e_data = e_data; v.e_grant = e_grant;
        v.e_busy = e_busy; v.e_to = e_to;
        return v;
    endfunction

    // Cycle where every output is expected low (reset or IDLE).
    function automatic vec_t idle_row(input logic rst, input logic [3:0] valid,
                                      input logic [3:0] last, input logic [31:0] data);
        return mk(rst, valid, last, data, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
    endfunction

    // Cycle where the owner's byte is written.
    function automatic vec_t acc_row(input logic [3:0] valid, input logic [3:0] last,
                                     input logic [31:0] data, input logic [7:0] e_data,
                                     input logic [3:0] owner);
        return mk(1'b0, valid, last, data, 1'b0, owner, 1'b1, e_data, owner, 1'b1, 1'b0);
    endfunction

    // Cycle where a grant is held but nothing is written.
    function automatic vec_t hold_row(input logic [3:0] valid, input logic [3:0] last,
                                      input logic [31:0] data, input logic full,
                                      input logic [3:0] owner);
        return mk(1'b0, valid, last, data, full, 4'b0000, 1'b0, 8'h00, owner, 1'b1, 1'b0);
    endfunction

    task automatic apply_row(input vec_t v, input string tag, input int idx);
        @(posedge clk);
        #1;
        reset     = v.rst;
        req_valid = v.valid;
        req_last  = v.last;
        req_data  = v.data;
        tx_full   = v.full;
        @(negedge clk);
        n_checks++;
        if ({req_ready, buffer_write, uart_data_write, grant, busy, timeout_release} ===
            {v.e_ready, v.e_bw, v.e_data, v.e_grant, v.e_busy, v.e_to}) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got rdy=%b bw=%b data=%h grant=%b busy=%b to=%b, want rdy=%b bw=%b data=%h grant=%b busy=%b to=%b",
                     tag, idx, req_ready, buffer_write, uart_data_write, grant, busy, timeout_release,
                     v.e_ready, v.e_bw, v.e_data, v.e_grant, v.e_busy, v.e_to);
        end
    endtask

    task automatic do_reset();
        apply_row(idle_row(1'b1, 4'b0000, 4'b0000, 32'h0), "reset", 0);
        apply_row(idle_row(1'b1, 4'b0000, 4'b0000, 32'h0), "reset", 1);
    endtask

    vec_t rr_tbl[16];

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'h0;
        req_data  = 32'hA6A4A2A0;
        tx_full   = 1'b0;

        // Reset with all requests high, then two-byte packets from every requester.
        rr_tbl[0]  = idle_row(1'b1, 4'hF, 4'b0000, 32'hA6A4A2A0);
        rr_tbl[1]  = idle_row(1'b1, 4'hF, 4'b0000, 32'hA6A4A2A0);
        rr_tbl[2]  = idle_row(1'b0, 4'hF, 4'b0000, 32'hA6A4A2A0);
        rr_tbl[3]  = acc_row(4'hF, 4'b0000, 32'hA6A4A2A0, 8'hA0, 4'b0001);
        rr_tbl[4]  = acc_row(4'hF, 4'b0001, 32'hA6A4A2A1, 8'hA1, 4'b0001);
        rr_tbl[5]  = idle_row(1'b0, 4'hF, 4'b0000, 32'hA6A4A2A0);
        rr_tbl[6]  = acc_row(4'hF, 4'b0000, 32'hA6A4A2A0, 8'hA2, 4'b0010);
        rr_tbl[7]  = acc_row(4'hF, 4'b0010, 32'hA6A4A3A0, 8'hA3, 4'b0010);
        rr_tbl[8]  = idle_row(1'b0, 4'hF, 4'b0000, 32'hA6A4A2A0);
        rr_tbl[9]  = acc_row(4'hF, 4'b0000, 32'hA6A4A2A0, 8'hA4, 4'b0100);
        rr_tbl[10] = acc_row(4'hF, 4'b0100, 32'hA6A5A2A0, 8'hA5, 4'b0100);
        rr_tbl[11] = idle_row(1'b0, 4'hF, 4'b0000, 32'hA6A4A2A0);
        rr_tbl[12] = acc_row(4'hF, 4'b0000, 32'hA6A4A2A0, 8'hA6, 4'b1000);
        rr_tbl[13] = acc_row(4'hF, 4'b1000, 32'hA7A4A2A0, 8'hA7, 4'b1000);
        rr_tbl[14] = idle_row(1'b0, 4'hF, 4'b0000, 32'hA6A4A2A0);
        rr_tbl[15] = acc_row(4'hF, 4'b0000, 32'hA6A4A2A0, 8'hA0, 4'b0001);

        for (int i = 0; i < 16; i++) begin
            apply_row(rr_tbl[i], "rr", i);
        end

        // Backpressure: 10 full cycles mid-packet must not write or time out.
        do_reset();
        apply_row(idle_row(1'b0, 4'b0010, 4'b0000, 32'h0000B000), "bp", 0);
        apply_row(acc_row(4'b0010, 4'b0000, 32'h0000B000, 8'hB0, 4'b0010), "bp", 1);
        for (int i = 0; i < 10; i++) begin
            apply_row(hold_row(4'b0010, 4'b0000, 32'h0000B100, 1'b1, 4'b0010), "bp_full", i);
        end
        apply_row(acc_row(4'b0010, 4'b0000, 32'h0000B100, 8'hB1, 4'b0010), "bp", 2);
        apply_row(acc_row(4'b0010, 4'b0010, 32'h0000B200, 8'hB2, 4'b0010), "bp", 3);
        apply_row(idle_row(1'b0, 4'b0000, 4'b0000, 32'h0), "bp", 4);

        // Byte limit: req1 truncated after four bytes, req2 served, req1 resumes.
        do_reset();
        apply_row(idle_row(1'b0, 4'b0110, 4'b0000, 32'h00201000), "lim", 0);
        apply_row(acc_row(4'b0110, 4'b0000, 32'h00201000, 8'h10, 4'b0010), "lim", 1);
        apply_row(acc_row(4'b0110, 4'b0000, 32'h00201100, 8'h11, 4'b0010), "lim", 2);
        apply_row(acc_row(4'b0110, 4'b0000, 32'h00201200, 8'h12, 4'b0010), "lim", 3);
        apply_row(acc_row(4'b0110, 4'b0000, 32'h00201300, 8'h13, 4'b0010), "lim", 4);
        apply_row(idle_row(1'b0, 4'b0110, 4'b0000, 32'h00201400), "lim", 5);
        apply_row(acc_row(4'b0110, 4'b0000, 32'h00201400, 8'h20, 4'b0100), "lim", 6);
        apply_row(acc_row(4'b0110, 4'b0100, 32'h00211400, 8'h21, 4'b0100), "lim", 7);
        apply_row(idle_row(1'b0, 4'b0010, 4'b0000, 32'h00001400), "lim", 8);
        apply_row(acc_row(4'b0010, 4'b0000, 32'h00001400, 8'h14, 4'b0010), "lim", 9);
        apply_row(acc_row(4'b0010, 4'b0010, 32'h00001500, 8'h15, 4'b0010), "lim", 10);
        apply_row(idle_row(1'b0, 4'b0000, 4'b0000, 32'h0), "lim", 11);

        // Timeout: req0 stalls for 8 cycles, pending req3 is granted next.
        do_reset();
        apply_row(idle_row(1'b0, 4'b1001, 4'b1000, 32'h77000055), "to", 0);
        apply_row(acc_row(4'b1001, 4'b1000, 32'h77000055, 8'h55, 4'b0001), "to", 1);
        for (int i = 0; i < 8; i++) begin
            apply_row(hold_row(4'b1000, 4'b1000, 32'h77000055, 1'b0, 4'b0001), "to_wait", i);
        end
        apply_row(mk(1'b0, 4'b1000, 4'b1000, 32'h77000055, 1'b0,
                     4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1), "to_pulse", 0);
        apply_row(acc_row(4'b1000, 4'b1000, 32'h77000055, 8'h77, 4'b1000), "to", 2);
        apply_row(idle_row(1'b0, 4'b0000, 4'b0000, 32'h0), "to", 3);

        // Reset mid-packet with ptr at 2; arbitration must restart from req0.
        do_reset();
        apply_row(idle_row(1'b0, 4'b0010, 4'b0010, 32'h00003100), "mid", 0);
        apply_row(acc_row(4'b0010, 4'b0010, 32'h00003100, 8'h31, 4'b0010), "mid", 1);
        apply_row(idle_row(1'b0, 4'b0101, 4'b0000, 32'h00500040), "mid", 2);
        apply_row(acc_row(4'b0101, 4'b0000, 32'h00500040, 8'h50, 4'b0100), "mid", 3);
        apply_row(acc_row(4'b0101, 4'b0000, 32'h00510040, 8'h51, 4'b0100), "mid", 4);
        apply_row(idle_row(1'b1, 4'b0101, 4'b0000, 32'h00520040), "mid_rst", 0);
        apply_row(idle_row(1'b1, 4'b0101, 4'b0000, 32'h00520040), "mid_rst", 1);
        apply_row(idle_row(1'b0, 4'b0101, 4'b0000, 32'h00520040), "mid", 5);
        apply_row(acc_row(4'b0101, 4'b0000, 32'h00520040, 8'h40, 4'b0001), "mid", 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locking arbiter that lets four on-chip requesters share the single transmit FIFO of the PicoBlaze UART (uart_tx6). It sits between the byte producers (PicoBlaze UART registers, accelerometer streamer, debug/status formatters) and the transmitter's `buffer_write`/`data_in` port. Each grant holds until the owner's packet ends, a per-grant byte limit is reached, or the owner stalls too long, so bytes from different sources never interleave inside a packet.

## Interface
Parameters:
- `MAX_PACKET`, default 16: maximum bytes accepted per grant, range 1..255.
- `TIMEOUT`, default 255: consecutive owner-idle cycles before a forced release, range 1..255.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 4: requester i has a byte on its data lane.
- `req_last` in 4: that byte is the last of requester i's packet.
- `req_data` in 32: requester i byte on `[8i+7:8i]`.
- `req_ready` out 4: byte of requester i accepted this cycle; at most one bit set.
- `buffer_write` out 1: write strobe to uart_tx6.
- `uart_data_write` out 8: byte to uart_tx6.
- `tx_full` in 1: uart_tx6 `buffer_full`.
- `grant` out 4: one-hot current owner; 0 when idle.
- `busy` out 1: a grant is held.
- `timeout_release` out 1: one-cycle pulse on a forced release by `TIMEOUT`.

## Operation
- State machine with two states: IDLE and LOCKED. Registers: `owner` (2b), `ptr` (2b round-robin pointer), `byte_cnt` (8b), `idle_cnt` (8b).
- IDLE: if any `req_valid`, select the first set bit searching `ptr, ptr+1, ptr+2, ptr+3` (mod 4). Load `owner`, clear both counters, go to LOCKED. No byte is accepted in IDLE.
- LOCKED: accept = `req_valid[owner] & ~tx_full`. On accept:
  - `req_ready[owner]=1`, `buffer_write=1` and `uart_data_write=req_data[owner lane]`, all in the same cycle (combinational from registered state, `req_valid` and `tx_full`).
  - `byte_cnt` increments.
- LOCKED, `req_valid[owner]=0`: `idle_cnt` increments; it clears on any cycle where owner valid is high. Stalls caused by `tx_full` with owner valid do not count.
- Release conditions, any of which returns the block to IDLE next cycle:
  - Accepted byte has `req_last[owner]`.
  - Accepted byte makes `byte_cnt==MAX_PACKET`.
  - `idle_cnt` reaches `TIMEOUT`; this pulses `timeout_release`.
- On release, `ptr <= owner+1` (mod 4).
- Non-owner requests are ignored while LOCKED; their `req_ready` stays 0. Requesters hold `req_data`/`req_last` stable while `req_valid` is high until `req_ready`.
- When `req_last` and the `MAX_PACKET` limit coincide on one byte, a single release occurs. A requester truncated by `MAX_PACKET` re-arbitrates for its remaining bytes.
- `uart_data_write` is 0 when `buffer_write` is 0.

## Timing
- Reset (async assert, sync deassert by system): IDLE, `ptr=0`, `owner=0`, counters 0. All outputs are 0: `req_ready`, `buffer_write`, `uart_data_write`, `grant`, `busy`, `timeout_release`.
- Reset mid-packet abandons the grant immediately; no write is issued while `reset` is high.
- Arbitration latency: `req_valid` rises in cycle N (IDLE), `grant`/`busy` are set in N+1, and the first accept can occur in N+1.
- Throughput: one byte per cycle while owner valid and `tx_full=0`.
- Inter-packet gap: exactly one IDLE cycle after each release.
- `grant`, `busy`, and `timeout_release` are registered outputs.
- `tx_full` is sampled in the same cycle as the write; uart_tx6 updates full on the following edge, so no write is ever issued while `tx_full=1`.
- Timeout: the owner is idle from cycle M; `timeout_release` pulses and the block is IDLE at M+`TIMEOUT`.

## Test plan
- Reset values: assert `reset` with all `req_valid=4'hF`, then check every output is 0. Release reset; `grant=4'b0001` one cycle later.
- Round-robin: all four requesters send 2-byte packets (`0xA0..0xA7`) continuously. The FIFO byte order must be A0,A1 (req0), A2,A3 (req1), A4,A5 (req2), A6,A7 (req3), then req0 again, with one idle cycle between packets.
- Backpressure: hold `tx_full=1` for 10 cycles mid-packet with owner valid. Check no `buffer_write`, no `req_ready`, no timeout, and the packet resumes intact once `tx_full` drops.
- Byte limit: `MAX_PACKET=4`, req1 sends 6 bytes (`0x10..0x15`) with no `req_last` until the 6th, while req2 is also requesting. Check 0x10..0x13, release, req2's packet, then 0x14,0x15.
- Timeout: `TIMEOUT=8`, req0 sends one byte without `req_last`, then drops valid. Check `timeout_release` pulses 8 cycles later and req3 (pending) is granted on the next cycle.
- Reset mid-packet: assert `reset` after 2 of 5 bytes. Check `buffer_write` drops immediately, and after deassertion arbitration restarts from `ptr=0`.
